// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: byte-addressed RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW to word accesses.
// Define MISALIGN_SPLIT_EN to run word-crossing accesses as two beats; otherwise they fault.
//   state | meaning
//   IDLE  | ready, waiting for a request
//   ACC1  | first (or only) memory beat
//   ACC2  | second beat of a word-crossing access
//   RESP  | response held until consumed
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] addrL_LSU,
  output logic [31:0] addrS_LSU,
  output logic [31:0] store,
  input  logic [31:0] data_rd,
  output logic        wr_E,
  output logic        cs_E,
  output logic [3:0]  mask,
  output logic        Data_Memory_on
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state, state_nxt;

  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  full_q;
  logic [31:0] w1_q, w2_q;
  logic [63:0] wdata_q;
  logic [31:0] lo_q;
  logic        split_q;

  logic [3:0]  size_m;
  logic [7:0]  full_in;
  logic        illegal_in, fault_in;
  logic [31:0] w_in, w2_in;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_m = 4'b0001;
      2'b01:   size_m = 4'b0011;
      default: size_m = 4'b1111;
    endcase
    full_in    = {4'b0000, size_m} << req_addr[1:0];
    illegal_in = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) || (req_wr && req_funct3[2]);
`ifdef MISALIGN_SPLIT_EN
    fault_in   = illegal_in;
`else
    fault_in   = illegal_in || (full_in[7:4] != 4'b0000);
`endif
    w_in  = {2'b00, req_addr[31:2]} % MEM_WORDS;
    w2_in = (w_in == MEM_WORDS - 1) ? 32'd0 : w_in + 32'd1;
  end

`ifdef MISALIGN_SPLIT_EN
  assign split_q = (full_q[7:4] != 4'b0000);
`else
  assign split_q = 1'b0;
`endif

  // Align {hi,lo} by the byte offset, then truncate and extend to the access size.
  function automatic logic [31:0] load_ext(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off, input logic [2:0] f3);
    logic [63:0] sh;
    sh = {hi, lo} >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   load_ext = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
      2'b01:   load_ext = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
      default: load_ext = sh[31:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    cs_E       = 1'b1;
    wr_E       = 1'b0;
    mask       = 4'b0000;
    store      = 32'd0;
    addrL_LSU  = w1_q;
    addrS_LSU  = w1_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = fault_in ? RESP : ACC1;
      end
      ACC1: begin
        cs_E      = 1'b0;
        wr_E      = wr_q;
        mask      = full_q[3:0];
        store     = wr_q ? wdata_q[31:0] : 32'd0;
        state_nxt = split_q ? ACC2 : RESP;
      end
      ACC2: begin
        cs_E      = 1'b0;
        wr_E      = wr_q;
        addrL_LSU = w2_q;
        addrS_LSU = w2_q;
        mask      = full_q[7:4];
        store     = wr_q ? wdata_q[63:32] : 32'd0;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q           <= 1'b0;
      funct3_q       <= 3'd0;
      off_q          <= 2'd0;
      full_q         <= 8'd0;
      w1_q           <= 32'd0;
      w2_q           <= 32'd0;
      wdata_q        <= 64'd0;
      lo_q           <= 32'd0;
      resp_rdata     <= 32'd0;
      resp_fault     <= 1'b0;
      Data_Memory_on <= 1'b0;
    end else begin
      Data_Memory_on <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            full_q     <= full_in;
            w1_q       <= w_in;
            w2_q       <= w2_in;
            wdata_q    <= {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
            resp_rdata <= 32'd0;
            resp_fault <= fault_in;
          end
        end
        ACC1: begin
          if (!wr_q) begin
            if (split_q) lo_q <= data_rd;
            else         resp_rdata <= load_ext(32'd0, data_rd, off_q, funct3_q);
          end
        end
        ACC2: begin
          if (!wr_q) resp_rdata <= load_ext(data_rd, lo_q, off_q, funct3_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: behavioural word memory, byte-level reference model and
// a response scoreboard. Split-mode expectations follow MISALIGN_SPLIT_EN when defined.
module tb_lsu_mem_master;
  localparam int MW = 256;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata, addrL_LSU, addrS_LSU, store, data_rd;
  logic        wr_E, cs_E, Data_Memory_on;
  logic [3:0]  mask;

  lsu_mem_master #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .addrL_LSU(addrL_LSU), .addrS_LSU(addrS_LSU), .store(store), .data_rd(data_rd),
    .wr_E(wr_E), .cs_E(cs_E), .mask(mask), .Data_Memory_on(Data_Memory_on)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  logic        mem_loaded = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h8001_5A3C;
    return (32'h9E37_79B9 * 32'(i + 7)) ^ 32'h5A5A_0F0F;
  endfunction

  assign data_rd = (addrL_LSU < 32'(MW)) ? mem[addrL_LSU[7:0]] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (!cs_E && wr_E && addrS_LSU < 32'(MW)) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mem[addrS_LSU[7:0]][8*b +: 8] <= store[8*b +: 8];
    end
  end

  // per-transaction observation of the memory side
  int          nbeat, cs_cnt;
  logic        ob_wr [2];
  logic [31:0] ob_addrL [2];
  logic [31:0] ob_addrS [2];
  logic [3:0]  ob_mask [2];
  logic [31:0] ob_store [2];

  // Byte-by-byte reference: updates ref_mem for stores, pushes the expected response.
  task automatic predict(input bit wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n, off, wi, ln;
    logic [31:0] t, rd;
    exp_t e;
    off = int'(addr[1:0]);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e.fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    if (!SPLIT && off + n > 4) e.fault = 1'b1;
    rd = 32'd0;
    if (e.fault) e.lat = 1;
    else begin
      e.lat = (off + n > 4) ? 3 : 2;
      for (int i = 0; i < n; i++) begin
        t  = (addr >> 2) + 32'((off + i) >> 2);
        wi = int'(t % 32'(MW));
        ln = (off + i) % 4;
        if (wr) ref_mem[wi][8*ln +: 8] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[wi][8*ln +: 8];
      end
      if (!wr && !f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
    end
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the DUT idle; returns the response and its latency.
  task automatic do_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat);
    predict(wr, f3, addr, wd);
    req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nbeat = 0; cs_cnt = 0;
    while (!resp_valid && lat < 16) begin
      if (!cs_E) begin
        cs_cnt++;
        if (nbeat < 2) begin
          ob_wr[nbeat] = wr_E; ob_addrL[nbeat] = addrL_LSU; ob_addrS[nbeat] = addrS_LSU;
          ob_mask[nbeat] = mask; ob_store[nbeat] = store;
          nbeat++;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; flt = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if ({resp_rdata, resp_fault} !== 33'd0) begin bad++; $display("FAIL rst_resp: got %h/%b want 0/0", resp_rdata, resp_fault); end
    total++; if ({cs_E, wr_E, mask} !== 6'b100000) begin bad++; $display("FAIL rst_mem_ctl: got cs=%b wr=%b mask=%b want 1/0/0000", cs_E, wr_E, mask); end
    total++; if (store !== 32'd0) begin bad++; $display("FAIL rst_store: got %h want 0", store); end
    total++; if (Data_Memory_on !== 1'b0) begin bad++; $display("FAIL rst_mem_on: got %b want 0", Data_Memory_on); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (Data_Memory_on !== 1'b1) begin bad++; $display("FAIL mem_on_run: got %b want 1", Data_Memory_on); end
  endtask

  task automatic test_store_word();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    do_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL sw_resp: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", rd, flt, lat, e.rdata, e.fault, e.lat); end
    total++; if (nbeat !== 1 || ob_wr[0] !== 1'b1 || ob_addrS[0] !== 32'd4 || ob_mask[0] !== 4'b1111) begin bad++;
      $display("FAIL sw_beat: got n=%0d wr=%b addrS=%h mask=%b want 1/1/4/1111", nbeat, ob_wr[0], ob_addrS[0], ob_mask[0]); end
    total++; if (ob_store[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_store: got %h want deadbeef", ob_store[0]); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    do_txn(1'b1, 3'b000, 32'h13, 32'h1234_56A5, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (nbeat !== 1 || ob_mask[0] !== 4'b1000 || ob_store[0][31:24] !== 8'hA5) begin bad++;
      $display("FAIL sb_beat: got n=%0d mask=%b lane3=%h want 1/1000/a5", nbeat, ob_mask[0], ob_store[0][31:24]); end
    total++; if ({flt, 8'(lat)} !== {e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL sb_resp: got f=%b lat=%0d want f=%b lat=%0d", flt, lat, e.fault, e.lat); end
    do_txn(1'b0, 3'b000, 32'h13, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (rd !== 32'hFFFF_FFA5 || rd !== e.rdata) begin bad++; $display("FAIL lb_rdata: got %h want ffffffa5", rd); end
    do_txn(1'b0, 3'b100, 32'h13, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL lbu_resp: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", rd, flt, lat, e.rdata, e.fault, e.lat); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    do_txn(1'b0, 3'b101, 32'h06, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (ob_addrL[0] !== 32'd1) begin bad++; $display("FAIL lhu_addr: got %h want 1", ob_addrL[0]); end
    total++; if (rd !== 32'h0000_8001 || lat !== e.lat) begin bad++; $display("FAIL lhu_rdata: got %h lat=%0d want 00008001 lat=%0d", rd, lat, e.lat); end
    do_txn(1'b0, 3'b001, 32'h06, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (rd !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_rdata: got %h want ffff8001", rd); end
    // word index wraps modulo the memory depth
    do_txn(1'b0, 3'b010, 32'h0000_1010, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (ob_addrL[0] !== 32'd4 || rd !== e.rdata) begin bad++; $display("FAIL lw_wrap: got addr=%h rd=%h want 4/%h", ob_addrL[0], rd, e.rdata); end
    do_txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (ob_addrL[0] !== 32'd255 || rd !== e.rdata) begin bad++; $display("FAIL lw_top: got addr=%h rd=%h want ff/%h", ob_addrL[0], rd, e.rdata); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    do_txn(1'b1, 3'b010, 32'h0B, 32'h1122_3344, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL sw_mis_resp: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", rd, flt, lat, e.rdata, e.fault, e.lat); end
`ifdef MISALIGN_SPLIT_EN
    total++; if (nbeat !== 2 || ob_addrS[0] !== 32'd2 || ob_mask[0] !== 4'b1000 || ob_store[0][31:24] !== 8'h44) begin bad++;
      $display("FAIL sw_mis_beat1: got n=%0d addr=%h mask=%b lane3=%h", nbeat, ob_addrS[0], ob_mask[0], ob_store[0][31:24]); end
    total++; if (ob_addrS[1] !== 32'd3 || ob_mask[1] !== 4'b0111 || ob_store[1][23:0] !== 24'h112233) begin bad++;
      $display("FAIL sw_mis_beat2: got addr=%h mask=%b lanes=%h", ob_addrS[1], ob_mask[1], ob_store[1][23:0]); end
`else
    total++; if (cs_cnt !== 0 || flt !== 1'b1 || lat !== 1) begin bad++;
      $display("FAIL sw_mis_fault: got cs_low=%0d f=%b lat=%0d want 0/1/1", cs_cnt, flt, lat); end
`endif
    do_txn(1'b0, 3'b010, 32'h3FE, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL lw_edge_resp: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", rd, flt, lat, e.rdata, e.fault, e.lat); end
`ifdef MISALIGN_SPLIT_EN
    total++; if (ob_addrL[0] !== 32'd255 || ob_addrL[1] !== 32'd0) begin bad++;
      $display("FAIL lw_edge_wrap: got %h,%h want ff,0", ob_addrL[0], ob_addrL[1]); end
`endif
    do_txn(1'b0, 3'b001, 32'h07, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
      $display("FAIL lh_mis_resp: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", rd, flt, lat, e.rdata, e.fault, e.lat); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    logic [3:0] codes [5] = '{4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    for (int i = 0; i < 5; i++) begin
      do_txn(codes[i][3], codes[i][2:0], 32'h20, 32'h0BAD_0BAD, rd, flt, lat);
      e = exp_q.pop_front();
      total++; if (flt !== 1'b1 || rd !== 32'd0 || lat !== 1 || cs_cnt !== 0) begin bad++;
        $display("FAIL illegal_%0d: got f=%b rd=%h lat=%0d cs_low=%0d want 1/0/1/0", i, flt, rd, lat, cs_cnt); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    logic ok;
    predict(1'b0, 3'b010, 32'h10, 32'd0);
    e = exp_q.pop_front();
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h0;
    n = 0;
    while (!resp_valid && n < 16) begin @(posedge clk); #1; n++; end
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_rdata === e.rdata && resp_fault === 1'b0)) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) begin bad++;
      $display("FAIL hold_stable: got v=%b rdy=%b rd=%h f=%b want 1/0/%h/0", resp_valid, req_ready, resp_rdata, resp_fault, e.rdata); end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++;
      $display("FAIL hold_release: got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat; exp_t e;
    logic seen;
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (cs_E !== 1'b0) begin bad++; $display("FAIL rmid_acc: got cs=%b want 0", cs_E); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || cs_E !== 1'b1) begin bad++;
      $display("FAIL rmid_idle: got rdy=%b v=%b cs=%b want 1/0/1", req_ready, resp_valid, cs_E); end
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_noresp: got resp_valid seen=%b want 0", seen); end
    // a store beat caught by reset still lands in memory
    predict(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D);
    e = exp_q.pop_back();
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 3'b010, 32'h24, 32'd0, rd, flt, lat);
    e = exp_q.pop_front();
    total++; if (rd !== 32'hCAFE_F00D || rd !== e.rdata) begin bad++; $display("FAIL rmid_store: got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, a; logic flt; int lat; exp_t e;
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 255));
      if (i % 7 == 3) a = a | 32'h0001_0000;
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), rd, flt, lat);
      e = exp_q.pop_front();
      total++; if ({rd, flt, 8'(lat)} !== {e.rdata, e.fault, 8'(e.lat)}) begin bad++;
        $display("FAIL b2b_%0d @%h: got rd=%h f=%b lat=%0d want rd=%h f=%b lat=%0d", i, a, rd, flt, lat, e.rdata, e.fault, e.lat); end
    end
  endtask

  task automatic test_mem_image();
    int nbad, first;
    nbad = 0; first = -1;
    for (int i = 0; i < MW; i++)
      if (mem[i] !== ref_mem[i]) begin nbad++; if (first < 0) first = i; end
    total++; if (nbad !== 0) begin bad++;
      $display("FAIL mem_image: %0d words differ, first word %0d got %h want %h", nbad, first, mem[first], ref_mem[first]); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_misalign();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_mem_image();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
